// File: rtl/cla_pipe_addsub.sv
// ----------------------------------------------------------------------------
// cla_pipe_addsub
//
// Pipelined carry-lookahead adder/subtractor. Each pipeline stage resolves one
// GROUP-bit slice with a full lookahead carry network. The slice carry-out is
// registered into the next stage. Operand bits that have not been processed yet
// travel along with the beat (skew buffering). Sum bits that are already done
// are also carried forward unchanged. Latency is STAGES = WIDTH/GROUP cycles.
// Throughput is one beat per cycle.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle (= pipeline advance)
//   a, b       operands, WIDTH bits
//   cin        carry-in, add mode only
//   sub        0: a + b + cin, 1: a - b (a + ~b + 1)
//   out_valid  result beat valid
//   out_ready  consumer accepts the result
//   sum        result, modulo 2^WIDTH
//   cout       carry out of the MSB (in sub mode 1 = no borrow)
//   ovf        signed two's-complement overflow
//   zero       sum == 0
// ----------------------------------------------------------------------------
module cla_pipe_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned STAGES = WIDTH / GROUP;

    // Lookahead carries for one slice. Every carry is a sum of products of the
    // slice generate/propagate terms and the slice carry-in, so no carry is
    // built from a lower carry inside the slice.
    //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[1]g[0] | p[i]..p[0]c0
    function automatic logic [GROUP:0] cla_carries(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             c0
    );
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < int'(GROUP); i++) begin
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
            term = c0;
            for (int m = 0; m <= i; m++) begin
                term = term & p[m];
            end
            c[i+1] = c[i+1] | term;
        end
        return c;
    endfunction

    // Per-stage state: valid bit, operand copies (upper bits still pending),
    // partial sum (lower bits already resolved) and the slice carry-out.
    logic             v_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];

    logic             v_d [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_d [STAGES];

    logic ovf_d, zero_d;
    logic ovf_q, zero_q;

    // The whole pipeline moves as one unit. It holds only when a result is
    // waiting and the consumer refuses it.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] SliceMask = WIDTH'({GROUP{1'b1}}) << (k * GROUP);

        logic [WIDTH-1:0] src_a, src_b, src_s;
        logic             src_c, src_v;
        logic [GROUP-1:0] ga, gb, g, p, slice_sum;
        logic [GROUP:0]   c;

        if (k == 0) begin : g_src_in
            // Subtract is a + ~b + 1; cin has no effect in that mode.
            assign src_a = a;
            assign src_b = sub ? ~b : b;
            assign src_c = sub | cin;
            assign src_s = '0;
            assign src_v = in_valid;
        end else begin : g_src_prev
            assign src_a = a_q[k-1];
            assign src_b = b_q[k-1];
            assign src_c = c_q[k-1];
            assign src_s = s_q[k-1];
            assign src_v = v_q[k-1];
        end

        assign ga        = src_a[k*GROUP +: GROUP];
        assign gb        = src_b[k*GROUP +: GROUP];
        assign g         = ga & gb;
        assign p         = ga ^ gb;
        assign c         = cla_carries(g, p, src_c);
        assign slice_sum = p ^ c[GROUP-1:0];

        assign v_d[k] = src_v;
        assign a_d[k] = src_a;
        assign b_d[k] = src_b;
        assign c_d[k] = c[GROUP];
        assign s_d[k] = (src_s & ~SliceMask) | (WIDTH'(slice_sum) << (k * GROUP));

        if (k == STAGES - 1) begin : g_flags
            // Overflow: the carry into the MSB differs from the carry out of it.
            assign ovf_d  = c[GROUP] ^ c[GROUP-1];
            assign zero_d = ~|s_d[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                v_q[k] <= v_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    // The last stage register is the output register.
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// ----------------------------------------------------------------------------
// tb_cla_pipe_addsub
//
// Scoreboard bench for cla_pipe_addsub (WIDTH=16, GROUP=4). The driver pushes
// the expected result of every accepted beat into a queue. The monitor runs
// on its own and pops one entry for each output transfer. Expected values
// come from plain integer arithmetic on the operands.
// ----------------------------------------------------------------------------
module tb_cla_pipe_addsub;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned GROUP  = 4;
    localparam int unsigned STAGES = WIDTH / GROUP;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin, sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout, ovf, zero;

    cla_pipe_addsub #(
        .WIDTH(WIDTH),
        .GROUP(GROUP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   lat_chk = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [15:0] xa, input logic [15:0] xb,
                                   input logic xc, input logic xs);
        exp_t        e;
        int unsigned ua, ub, ru;
        int          sa, sb, sr;
        ua = int'(xa);
        ub = int'(xb);
        sa = int'($signed(xa));
        sb = int'($signed(xb));
        if (xs) begin
            ru     = ua - ub;
            sr     = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            ru     = ua + ub + int'(xc);
            sr     = sa + sb + int'(xc);
            e.cout = (ru > 32'd65535);
        end
        e.sum  = ru[15:0];
        e.ovf  = (sr > 32767) || (sr < -32768);
        e.zero = (e.sum == 16'h0000);
        e.cyc  = 0;
        e.lat  = 1'b0;
        return e;
    endfunction

    task automatic send(input logic [15:0] xa, input logic [15:0] xb,
                        input logic xc, input logic xs);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        a        = xa;
        b        = xb;
        cin      = xc;
        sub      = xs;
        in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
            in_valid = 1'b0;
            return;
        end
        e     = model(xa, xb, xc, xs);
        e.cyc = cyc;
        e.lat = lat_chk;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: samples between edges, pops one entry per output transfer.
    logic        held = 1'b0;
    logic [15:0] h_sum;
    logic        h_cout, h_ovf, h_zero;

    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_sum", 32'(sum), 32'(h_sum));
                chk("hold_flags", {29'd0, cout, ovf, zero}, {29'd0, h_cout, h_ovf, h_zero});
            end
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got sum 0x%0h, expected no output", sum);
                end else begin
                    e = q.pop_front();
                    chk("sum", 32'(sum), 32'(e.sum));
                    chk("cout", 32'(cout), 32'(e.cout));
                    chk("ovf", 32'(ovf), 32'(e.ovf));
                    chk("zero", 32'(zero), 32'(e.zero));
                    if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'(STAGES));
                end
            end
            held   = out_valid && !out_ready;
            h_sum  = sum;
            h_cout = cout;
            h_ovf  = ovf;
            h_zero = zero;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_outputs", {11'd0, cout, ovf, zero, sum}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed add / sub cases, including cin ignored in sub mode.
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        drain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0000, 1'b1, 1'b0);
        send(16'h0005, 16'h0007, 1'b1, 1'b1);
        send(16'h8000, 16'h0001, 1'b1, 1'b1);
        send(16'h1234, 16'h1234, 1'b0, 1'b1);
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        drain();

        // Back-to-back random stream.
        for (int i = 0; i < 8; i++) send_rand();
        drain();

        // Backpressure: full pipe, consumer stalls 3 cycles.
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send_rand();
            end
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Random stalls and gaps.
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    send_rand();
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        // Reset with beats in flight and a result presented.
        for (int i = 0; i < 5; i++) send_rand();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_outputs", {11'd0, cout, ovf, zero, sum}, 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        drain();
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parameterised, pipelined carry-lookahead adder/subtractor. Processes one GROUP-bit lookahead slice per pipeline stage.
- Stage-to-stage carry is registered, so throughput is one operation per clock at any WIDTH.
- Sits between operand-issue logic and result consumers in the datapath, with valid/ready handshakes on both sides.
- Next generation of our fixed 4/8-bit combinational CLAs: adds width generalisation, subtract mode, flags and backpressure.

Parameters:
- WIDTH, 16, operand/result width. Must be a multiple of GROUP.
- GROUP, 4, bits per lookahead slice. One slice per pipeline stage. Legal values 2..8.
- STAGES, WIDTH/GROUP, derived localparam, never overridden. Equals the pipeline latency in cycles.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; used in add mode only
- sub  in  1  0 = A+B+cin, 1 = A-B (A + ~B + 1, cin ignored)
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB; in sub mode 1 = no borrow
- ovf  out  1  signed two's-complement overflow
- zero  out  1  sum == 0

Behaviour:
- Reset (async assert, sync-safe deassert to registers):
  - out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - All stage valid bits cleared; all in-flight beats discarded.
  - in_ready=1 from the first cycle after reset.
- Handshake:
  - Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
  - adv = ~out_valid | out_ready. in_ready = adv, combinational from out_ready/out_valid only, no dependency on in_valid.
  - When adv=0 the whole pipeline holds, including every stage register.
  - When adv=1 every stage shifts forward one position; a stage with no valid beat propagates a bubble (valid=0).
- Latency: a beat accepted in cycle t with no stalls presents out_valid=1 in cycle t+STAGES. Each stall cycle adds one.
- Throughput: one beat per cycle when out_ready is held 1.
- Capture at stage 0:
  - Effective B = sub ? ~b : b.
  - Effective carry-in = sub ? 1 : cin.
- Stage k (0..STAGES-1):
  - Computes slice k, bits [k*GROUP +: GROUP], with full lookahead: G=A&B, P=A^B, each carry as a sum-of-products of G/P and the slice carry-in, no internal ripple.
  - Registers the slice sum bits, the slice carry-out, and the not-yet-processed upper operand bits. This is skew buffering.
  - Already-computed lower sum bits travel forward unchanged.
- Final stage outputs:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|sum.
  - All four outputs are registered.
- Output stability: sum/cout/ovf/zero are held stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - In-transfer and out-transfer in the same cycle are both legal; a full pipeline stays full with no bubble.
  - in_valid may drop at any time; bubbles are carried and never presented as out_valid.
- Wrap-around:
  - Results are modulo 2^WIDTH; cout carries the overflow bit.
  - Sub with a==b gives sum=0, zero=1, cout=1, ovf=0.
- Reset mid-operation: all in-flight beats are lost, out_valid falls asynchronously, and no partial result is ever emitted.
- No X: unused upper bits in bubble stages may hold stale data, but outputs are qualified by out_valid. Flags are cleared on reset.

Test Plan (WIDTH=16, GROUP=4, STAGES=4):
- Add a=0x00FF, b=0x0001, cin=0, out_ready=1 -> exactly 4 cycles later sum=0x0100, cout=0, ovf=0, zero=0.
- Add a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, ovf=0. Then a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, ovf=1, cout=0.
- Sub a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Then sub a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1. Verifies cin is ignored by driving cin=1 on both.
- Stream 8 back-to-back random beats with out_ready=1 -> 8 consecutive out_valid cycles, in order, each matching the reference model (a ± b + cin) mod 2^16 including flags.
- Fill the pipe, then hold out_ready=0 for 3 cycles -> in_ready=0 in those cycles, sum held stable, and no beat lost or duplicated after out_ready returns to 1.
- Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 immediately and outputs zero. Next accepted beat 0x1234+0x1111 emerges as 0x2345 after 4 cycles with no stale results before it.
